shift_exec_unit: RTL and testbench

- Sequential execution stage in front of the combinational shift/rotate/swap logic: accepts one shift-class operation per transaction over a valid/ready handshake, computes it, and holds the result until the consumer (writeback) accepts it.
- Default build is a serial shifter that moves one bit position per clock to save area. The result semantics match the combinational SHFTR/SHFTL/ROTR/ROTL/SWAP operators bit for bit.

---
 rtl/shift_exec_unit.sv | 217 +++++++++++++++++++++
 tb/tb_shift_exec_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_unit.sv
// -----------------------------------------------------------------------------
// shift_exec_unit
//
// Sequential execution stage for shift-class operations (SHFTR, SHFTL, ROTR,
// ROTL, SWAP). One request is accepted over a valid/ready handshake. The unit
// computes the result and holds it until writeback accepts it.
//
// Build options:
//   SHIFT_EXEC_FAST_EN  undefined (default): serial shifter, one bit position
//                       per clock in the RUN state.
//                       defined: the full barrel result is formed at the
//                       accept edge; RUN is never entered.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  request handshake
//   op                 000 SHFTR, 001 SHFTL, 010 ROTR, 011 ROTL, 100 SWAP,
//                      101-111 illegal
//   data_a, data_b     operands (data_b is only used by SWAP)
//   amount             shift/rotate distance
//   out_valid/out_ready result handshake
//   result_a, result_b primary / secondary result
//   zero               result_a == 0
//   err                illegal opcode
//   busy               FSM is not in IDLE
//   dbg_state          current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// While out_valid is high, result_a, result_b, zero and err hold steady until
// the transfer completes. The FSM never accepts a new request in the same
// cycle that a result leaves.
// -----------------------------------------------------------------------------
module shift_exec_unit #(
  parameter int WIDTH = 20,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_a,
  output logic [WIDTH-1:0] result_b,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // WIDTH as an (AMT_W+1)-bit value, so that amount can be compared
  // without a width mismatch.
  localparam logic [AMT_W:0] WIDTH_A = (AMT_W + 1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_a_q, res_a_d;
  logic [WIDTH-1:0] res_b_q, res_b_d;
  logic             err_q, err_d;

`ifndef SHIFT_EXEC_FAST_EN
  // Serial datapath state: direction, rotate flag, remaining steps.
  logic             left_q, left_d;
  logic             rot_q, rot_d;
  logic [AMT_W-1:0] count_q, count_d;
`endif

  // Request decode
  logic is_shrot;
  logic is_swap;
  logic is_illegal;
  logic amt_zero;
  logic amt_ge_w;
  logic needs_steps;
  logic accept;

  assign is_shrot    = ~op[2];
  assign is_swap     = (op == 3'b100);
  assign is_illegal  = op[2] & (op[1] | op[0]);
  assign amt_zero    = (amount == '0);
  assign amt_ge_w    = ({1'b0, amount} >= WIDTH_A);
  // The only cases that do real shifting. Zero and oversize distances
  // resolve straight to DONE.
  assign needs_steps = is_shrot & ~amt_zero & ~amt_ge_w;
  assign accept      = in_valid & in_ready;

`ifndef SHIFT_EXEC_FAST_EN
  // Single-position step. left selects the direction. rot selects between
  // wrap-around and zero fill.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                             input logic             left,
                                             input logic             rot);
    logic [WIDTH-1:0] r;
    if (left) r = {v[WIDTH-2:0], rot ? v[WIDTH-1] : 1'b0};
    else      r = {rot ? v[0] : 1'b0, v[WIDTH-1:1]};
    return r;
  endfunction
`else
  // Full barrel result. The caller guarantees 1 <= amt <= WIDTH-1.
  // Rotates use a doubled word, so the wrapped bits fall into the
  // selected half.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       sel,
                                              input logic [AMT_W-1:0] amt);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    dbl = {v, v};
    case (sel)
      2'b00: r = v >> amt;
      2'b01: r = v << amt;
      2'b10: begin
        dbl = dbl >> amt;
        r   = dbl[WIDTH-1:0];
      end
      default: begin
        dbl = dbl << amt;
        r   = dbl[2*WIDTH-1:WIDTH];
      end
    endcase
    return r;
  endfunction
`endif

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    err_d   = err_q;
`ifndef SHIFT_EXEC_FAST_EN
    left_d  = left_q;
    rot_d   = rot_q;
    count_d = count_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = is_illegal;
          res_b_d = is_swap ? data_a : data_b;
          if (is_swap)                  res_a_d = data_b;
          else if (is_shrot & amt_ge_w) res_a_d = '0;
          else                          res_a_d = data_a;
`ifndef SHIFT_EXEC_FAST_EN
          left_d  = op[0];
          rot_d   = op[1];
          count_d = amount;
          state_d = needs_steps ? RUN : DONE;
`else
          if (needs_steps) res_a_d = barrel(data_a, op[1:0], amount);
          state_d = DONE;
`endif
        end
      end

      RUN: begin
`ifndef SHIFT_EXEC_FAST_EN
        res_a_d = step1(res_a_q, left_q, rot_q);
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_a_q <= '0;
      res_b_q <= '0;
      err_q   <= 1'b0;
`ifndef SHIFT_EXEC_FAST_EN
      left_q  <= 1'b0;
      rot_q   <= 1'b0;
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
      err_q   <= err_d;
`ifndef SHIFT_EXEC_FAST_EN
      left_q  <= left_d;
      rot_q   <= rot_d;
      count_q <= count_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result_a  = res_a_q;
  assign result_b  = res_b_q;
  assign zero      = (res_a_q == '0);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
module tb_shift_exec_unit;
  localparam int WIDTH = 20;
  localparam int AMT_W = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [AMT_W-1:0] amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_a;
  logic [WIDTH-1:0] result_b;
  logic             zero;
  logic             err;
  logic             busy;
  logic [1:0]       dbg_state;

  shift_exec_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data_a(data_a), .data_b(data_b), .amount(amount),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_a(result_a), .result_b(result_b), .zero(zero), .err(err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model, written from the result rules
  function automatic void model(input logic [2:0] m_op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [AMT_W-1:0] amt,
                                output logic [WIDTH-1:0] ra, output logic [WIDTH-1:0] rb,
                                output logic e, output int lat);
    int n;
    n   = int'(amt);
    ra  = a;
    rb  = b;
    e   = 1'b0;
    lat = 1;
    if (m_op <= 3'd3) begin
      if (n >= WIDTH) ra = '0;
      else if (n == 0) ra = a;
      else begin
        lat = n + 1;
        case (m_op)
          3'd0: ra = a >> n;
          3'd1: ra = a << n;
          3'd2: for (int i = 0; i < WIDTH; i++) ra[i] = a[(i + n) % WIDTH];
          default: for (int i = 0; i < WIDTH; i++) ra[i] = a[(i + WIDTH - n) % WIDTH];
        endcase
      end
    end else if (m_op == 3'd4) begin
      ra = b;
      rb = a;
    end else begin
      e = 1'b1;
    end
`ifdef SHIFT_EXEC_FAST_EN
    lat = 1;
`endif
  endfunction

  // driver: waits for in_ready, presents one request, scrambles the inputs
  // after the accept edge, then returns at the first negedge with out_valid
  task automatic send(input logic [2:0] s_op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [AMT_W-1:0] amt,
                      output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = s_op; data_a = a; data_b = b; amount = amt;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op     = 3'($urandom_range(0, 7));
    data_a = WIDTH'($urandom);
    data_b = WIDTH'($urandom);
    amount = AMT_W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // scoreboard check on the DONE cycle
  task automatic check_out(input string tag, input logic [WIDTH-1:0] rb,
                           input logic z, input logic e, input int exp_lat, input int lat);
    logic [WIDTH-1:0] q;
    q = exp_q.pop_front();
    chk({tag, "_result_a"}, 32'(result_a), 32'(q));
    chk({tag, "_result_b"}, 32'(result_b), 32'(rb));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  // completes the result handshake and checks the return to IDLE
  task automatic finish_txn(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             z;
    logic             e;
    int               lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, exp_lat, seen, k;
    logic [WIDTH-1:0] m_ra, m_rb, hold_a;
    logic m_e;
    logic [2:0] r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic [AMT_W-1:0] r_amt;

    vecs[0]  = '{3'd0, 20'hF0000, 20'h12345, 5'd4,  20'h0F000, 20'h12345, 1'b0, 1'b0, 5};
    vecs[1]  = '{3'd3, 20'h80001, 20'h00000, 5'd1,  20'h00003, 20'h00000, 1'b0, 1'b0, 2};
    vecs[2]  = '{3'd2, 20'h00001, 20'hABCDE, 5'd1,  20'h80000, 20'hABCDE, 1'b0, 1'b0, 2};
    vecs[3]  = '{3'd1, 20'h00001, 20'h00000, 5'd20, 20'h00000, 20'h00000, 1'b1, 1'b0, 1};
    vecs[4]  = '{3'd2, 20'h12345, 20'h0000F, 5'd0,  20'h12345, 20'h0000F, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd4, 20'hAAAAA, 20'h55555, 5'd3,  20'h55555, 20'hAAAAA, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd7, 20'h13579, 20'h2468A, 5'd2,  20'h13579, 20'h2468A, 1'b0, 1'b1, 1};
    vecs[7]  = '{3'd4, 20'h0F0F0, 20'h0F0F0, 5'd0,  20'h0F0F0, 20'h0F0F0, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd1, 20'h00001, 20'h00000, 5'd19, 20'h80000, 20'h00000, 1'b0, 1'b0, 20};
    vecs[9]  = '{3'd3, 20'h12345, 20'h00000, 5'd31, 20'h00000, 20'h00000, 1'b1, 1'b0, 1};
    vecs[10] = '{3'd5, 20'h00000, 20'h00001, 5'd7,  20'h00000, 20'h00001, 1'b1, 1'b1, 1};
    vecs[11] = '{3'd0, 20'hFFFFF, 20'h00000, 5'd19, 20'h00001, 20'h00000, 1'b0, 1'b0, 20};

    // reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; data_a = '0; data_b = '0; amount = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result_a", 32'(result_a), 32'd0);
    chk("rst_result_b", 32'(result_b), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // directed table
    for (int i = 0; i < 12; i++) begin
      exp_lat = vecs[i].lat;
`ifdef SHIFT_EXEC_FAST_EN
      exp_lat = 1;
`endif
      exp_q.push_back(vecs[i].ra);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].amt, lat);
      check_out($sformatf("vec%0d", i), vecs[i].rb, vecs[i].z, vecs[i].e, exp_lat, lat);
      finish_txn($sformatf("vec%0d", i));
    end

    // backpressure: hold DONE for 10 cycles
    out_ready = 1'b0;
    exp_q.push_back(20'h0F000);
    exp_lat = 5;
`ifdef SHIFT_EXEC_FAST_EN
    exp_lat = 1;
`endif
    send(3'd0, 20'hF0000, 20'h00000, 5'd4, lat);
    check_out("bp", 20'h00000, 1'b0, 1'b0, exp_lat, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result_a", c), 32'(result_a), 32'h0F000);
      chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    finish_txn("bp");

    // reset during RUN
    in_valid = 1'b1; op = 3'd1; data_a = 20'h00001; data_b = '0; amount = 5'd15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result_a", 32'(result_a), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_spurious", 32'(seen), 32'd0);
    exp_q.push_back(20'h80000);
    exp_lat = 2;
`ifdef SHIFT_EXEC_FAST_EN
    exp_lat = 1;
`endif
    send(3'd2, 20'h00001, 20'h00000, 5'd1, lat);
    check_out("midrst_next", 20'h00000, 1'b0, 1'b0, exp_lat, lat);
    finish_txn("midrst_next");

    // randomized against the model
    for (int t = 0; t < 150; t++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_a   = WIDTH'($urandom);
      r_b   = WIDTH'($urandom);
      r_amt = AMT_W'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r_a = '0;
      model(r_op, r_a, r_b, r_amt, m_ra, m_rb, m_e, exp_lat);
      exp_q.push_back(m_ra);
      k = $urandom_range(0, 3);
      out_ready = (k == 0);
      send(r_op, r_a, r_b, r_amt, lat);
      hold_a = result_a;
      check_out($sformatf("rnd%0d", t), m_rb, (m_ra == '0), m_e, exp_lat, lat);
      if (k != 0) begin
        repeat (k) @(negedge clk);
        chk($sformatf("rnd%0d_hold", t), 32'(result_a), 32'(hold_a));
      end
      finish_txn($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
